// File: rtl/mem_fifo_sched.sv
// mem_fifo_sched: sequences producer writes and consumer reads onto the memory core in FIFO mode,
// tracking core occupancy and absorbing the one-cycle read latency in a 2-entry output buffer.
module mem_fifo_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic [CNT_WIDTH-1:0]  depth,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic                  pop_ready,
    output logic                  mem_wen_in,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_ren_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_valid_out,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  full,
    output logic                  empty,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic [CNT_WIDTH-1:0] cnt_one = 1;
    state_t                state, state_d;
    logic [CNT_WIDTH-1:0]  occ_q, occ_d, depth_q, depth_d;
    logic [DATA_WIDTH-1:0] buf0, buf1, buf0_d, buf1_d;
    logic [1:0]            buf_count, count_d, wpos;
    logic                  inflight, inflight_d, err_q, err_d, pop, wr, wr_ok;
    assign push_ready  = clk_en && state == RUN && occ_q < depth_q;
    assign mem_wen_in  = push_valid && push_ready;
    assign mem_data_in = push_data;
    assign mem_ren_in  = clk_en && state == RUN && occ_q != '0 && ({1'b0, inflight} + buf_count) < 2'd2;
    assign pop_valid   = buf_count != 2'd0;
    assign pop_data    = buf0;
    assign occupancy   = occ_q;
    assign full        = depth_q != '0 && occ_q == depth_q;
    assign empty       = occ_q == '0 && buf_count == 2'd0;
    assign err         = err_q;
    assign pop         = pop_valid && pop_ready && clk_en;
    assign wr          = mem_valid_out && clk_en;
    // Slot the returning word lands in, after any same-cycle pop has shifted the buffer.
    assign wpos        = buf_count - {1'b0, pop};
    assign wr_ok       = wr && wpos != 2'd2;
    always_comb begin
        state_d    = state;
        depth_d    = depth_q;
        inflight_d = clk_en ? mem_ren_in : inflight;
        buf0_d     = pop ? buf1 : buf0;
        buf1_d     = buf1;
        if (wr_ok && wpos == 2'd0) buf0_d = mem_data_out;
        if (wr_ok && wpos == 2'd1) buf1_d = mem_data_out;
        count_d    = buf_count + {1'b0, wr_ok} - {1'b0, pop};
        occ_d      = (mem_wen_in && !mem_ren_in) ? occ_q + cnt_one :
                     (mem_ren_in && !mem_wen_in) ? occ_q - cnt_one : occ_q;
        err_d      = err_q
                   | (wr && !inflight)
                   | (clk_en && inflight && !mem_valid_out)
                   | (wr && buf_count == 2'd2)
                   | (mem_wen_in && !mem_ren_in && &occ_q)
                   | (mem_ren_in && !mem_wen_in && occ_q == '0);
        case (state)
            IDLE: begin
                if (clk_en && !flush && depth != '0) begin
                    state_d = RUN;
                    depth_d = depth;
                end
            end
            RUN: begin
                if (clk_en && flush) state_d = DRAIN;
            end
            DRAIN: begin
                // Wait for the outstanding return, discard everything, then leave on the next enabled cycle.
                if (clk_en && !inflight) begin
                    if (occ_q == '0 && buf_count == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        occ_d   = '0;
                        count_d = 2'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            occ_q     <= '0;
            depth_q   <= '0;
            inflight  <= 1'b0;
            buf_count <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            occ_q     <= occ_d;
            depth_q   <= depth_d;
            inflight  <= inflight_d;
            buf_count <= count_d;
            buf0      <= buf0_d;
            buf1      <= buf1_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_fifo_sched.sv
// tb_mem_fifo_sched: random and directed traffic against a queue-based core model and an
// in-order scoreboard; pops are compared as they appear, independent of the stimulus.
`timescale 1ns/1ps
module tb_mem_fifo_sched;
    localparam int DW = 16;
    localparam int CW = 16;
    logic          clk = 1'b0, reset = 1'b1, clk_en = 1'b0, flush = 1'b0;
    logic          push_valid = 1'b0, pop_ready = 1'b0, inj = 1'b0, core_clr = 1'b0, inv_en = 1'b1;
    logic [CW-1:0] depth = '0;
    logic [DW-1:0] push_data = '0;
    logic          push_ready, pop_valid, mem_wen_in, mem_ren_in, mem_valid_out, full, empty, err;
    logic [DW-1:0] pop_data, mem_data_in, mem_data_out, mem_rd, mon_exp, seq, pd_s;
    logic [CW-1:0] occupancy, occ_s;
    logic          mem_vr, pv_s;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] memq[$];
    int            tests = 0, fails = 0, dmodel = 0;

    mem_fifo_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .depth(depth),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
        .mem_wen_in(mem_wen_in), .mem_data_in(mem_data_in), .mem_ren_in(mem_ren_in),
        .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out),
        .occupancy(occupancy), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;
    assign mem_valid_out = mem_vr | inj;
    assign mem_data_out  = mem_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory core: plain word queue with exactly one enabled cycle of read latency.
    always @(posedge clk) begin
        if (reset || core_clr) begin
            memq.delete();
            mem_vr <= 1'b0;
            mem_rd <= '0;
        end else if (clk_en) begin
            mem_vr <= mem_ren_in;
            if (mem_ren_in && memq.size() != 0) mem_rd <= memq.pop_front();
            if (mem_wen_in) memq.push_back(mem_data_in);
        end
    end

    // Stimulus side of the scoreboard: every accepted push is expected later, in order.
    always @(negedge clk) begin
        if (!reset && push_valid && push_ready) exp_q.push_back(push_data);
    end

    // Monitor: compares each completed pop and checks invariants that follow from the rules.
    always @(negedge clk) begin
        if (!reset) begin
            if (inv_en) begin
                check("ren_only_when_occupied", 32'(mem_ren_in && occupancy == '0), 0);
                if (!clk_en) check("strobes_gated", {29'd0, mem_wen_in, mem_ren_in, push_ready}, 0);
                check("full_flag", 32'(full), 32'(dmodel != 0 && int'(occupancy) == dmodel));
                check("occ_le_held", 32'(int'(occupancy) <= exp_q.size()), 1);
                if (exp_q.size() == 0) check("empty_when_nothing_held", 32'(empty), 1);
            end
            if (pop_valid && pop_ready && clk_en) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected_word", 32'(pop_data), 32'hdead_beef);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("pop_data_order", 32'(pop_data), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench still running, required to reach finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_traffic(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            clk_en     = rnd ? 1'($urandom_range(0, 7) != 0) : 1'b1;
            push_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pop_ready  = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            push_data  = seq;
            @(negedge clk);
            if (push_valid && push_ready) seq = seq + 16'd1;
            cyc();
        end
        clk_en     = 1'b1;
        push_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        pop_ready  = 1'b1;
        push_valid = 1'b0;
        clk_en     = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (empty && !pop_valid && !mem_valid_out) done = 1;
            cyc();
        end
        check({name, "_drained"}, 32'(done), 1);
        check({name, "_all_delivered"}, exp_q.size(), 0);
    endtask

    task automatic do_flush();
        bit done = 0;
        flush      = 1'b1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (empty && !pop_valid && occupancy == '0 && !mem_valid_out) done = 1;
            cyc();
        end
        check("flush_completes", 32'(done), 1);
        cyc();
        @(negedge clk);
        check("flush_idle_no_push", 32'(push_ready), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_occ", 32'(occupancy), 0);
        cyc();
        core_clr = 1'b1;
        cyc();
        core_clr = 1'b0;
        exp_q.delete();
        flush = 1'b0;
    endtask

    initial begin
        int acc, ren_k, pop_k;
        seq = 16'h0100;
        repeat (2) cyc();
        @(negedge clk);
        check("rst_push_ready", 32'(push_ready), 0);
        check("rst_pop_valid", 32'(pop_valid), 0);
        check("rst_pop_data", 32'(pop_data), 0);
        check("rst_wen", 32'(mem_wen_in), 0);
        check("rst_ren", 32'(mem_ren_in), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_err", 32'(err), 0);
        cyc();
        reset = 1'b0; clk_en = 1'b1; depth = 16'd4; dmodel = 4;
        cyc();
        // Fill with the consumer stalled: 2 words park in the buffer, 4 in the core.
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            push_valid = 1'b1;
            push_data  = 16'h0011 + 16'(acc);
            @(negedge clk);
            if (push_ready) acc++;
            cyc();
        end
        push_valid = 1'b0;
        check("fill_accepted", 32'(acc), 6);
        @(negedge clk);
        check("fill_full", 32'(full), 1);
        check("fill_occ", 32'(occupancy), 4);
        check("fill_push_ready", 32'(push_ready), 0);
        check("fill_pop_valid", 32'(pop_valid), 1);
        cyc();
        drain("full_drain");
        check("full_drain_err", 32'(err), 0);
        // Single word latency: ren one cycle after the push, pop_valid two after ren.
        pop_ready = 1'b0; push_valid = 1'b1; push_data = 16'h0abc;
        ren_k = -1; pop_k = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_ren_in && ren_k < 0) ren_k = k;
            if (pop_valid && pop_k < 0) pop_k = k;
            cyc();
            push_valid = 1'b0;
        end
        check("lat_ren", 32'(ren_k), 1);
        check("lat_pop_valid", 32'(pop_k), 3);
        drain("lat_drain");
        do_flush();
        depth = 16'd2; dmodel = 2;
        cyc();
        run_traffic(30, 0);
        clk_en = 1'b0; push_valid = 1'b1; pop_ready = 1'b1; push_data = seq;
        @(negedge clk);
        occ_s = occupancy; pv_s = pop_valid; pd_s = pop_data;
        check("hold_wen", 32'(mem_wen_in), 0);
        check("hold_ren", 32'(mem_ren_in), 0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("hold_strobes", {30'd0, mem_wen_in, mem_ren_in}, 0);
            check("hold_occ", 32'(occupancy), 32'(occ_s));
            check("hold_pop_valid", 32'(pop_valid), 32'(pv_s));
            check("hold_pop_data", 32'(pop_data), 32'(pd_s));
            cyc();
        end
        clk_en = 1'b1;
        run_traffic(30, 0);
        run_traffic(200, 1);
        drain("stream_drain");
        do_flush();
        // Flush while 3 words sit in the core and a read is returning.
        depth = 16'd6; dmodel = 6;
        cyc();
        pop_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1; push_data = seq;
            @(negedge clk);
            check("fl_push_ready", 32'(push_ready), 1);
            seq = seq + 16'd1;
            cyc();
        end
        push_valid = 1'b0;
        @(negedge clk);
        check("fl_occ_before", 32'(occupancy), 3);
        cyc();
        pop_ready = 1'b1;
        cyc();
        pop_ready = 1'b0; push_valid = 1'b1; push_data = seq;
        @(negedge clk);
        check("fl_ren_with_wen", {30'd0, mem_ren_in, mem_wen_in}, 3);
        seq = seq + 16'd1;
        cyc();
        push_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("fl_occ_at_flush", 32'(occupancy), 3);
        check("fl_return_in_flight", 32'(mem_valid_out), 1);
        cyc();
        @(negedge clk);
        check("drain_no_push", 32'(push_ready), 0);
        check("drain_no_ren", 32'(mem_ren_in), 0);
        cyc();
        do_flush();
        check("fl_err", 32'(err), 0);
        depth = 16'd8; dmodel = 8;
        cyc();
        run_traffic(150, 1);
        // Reset mid-stream: in-flight data is dropped and err stays clear.
        reset = 1'b1; pop_ready = 1'b0;
        cyc();
        reset = 1'b0; exp_q.delete(); dmodel = 0;
        @(negedge clk);
        check("mid_rst_occ", 32'(occupancy), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_pop_valid", 32'(pop_valid), 0);
        cyc();
        cyc();
        @(negedge clk);
        check("mid_rst_err", 32'(err), 0);
        cyc();
        depth = 16'd8; dmodel = 8;
        cyc();
        run_traffic(100, 1);
        drain("post_rst_drain");
        // Spurious core valid with nothing in flight.
        inv_en = 1'b0; pop_ready = 1'b0; inj = 1'b1;
        @(negedge clk);
        check("inj_err_same_cycle", 32'(err), 0);
        cyc();
        inj = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("inj_err_sticky", 32'(err), 1);
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0; exp_q.delete(); dmodel = 0;
        @(negedge clk);
        check("inj_err_cleared", 32'(err), 0);
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
